// File: rtl/ls_bus_master_if.sv
// rtl/ls_bus_master_if.sv - external peripheral bus request/ready interface
interface ls_bus_master_if;
    logic        bus_req;
    logic        bus_we;
    logic [16:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/ls_bus_master.sv
// rtl/ls_bus_master.sv - load/store enable to registered request/ready bus master with timeout
module ls_bus_master #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 8,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ls_bus_rd_en,
    input  logic                ls_bus_wr_en,
    input  logic [16:0]         ls_bus_addr,
    input  logic [31:0]         ls_bus_write_data,
    output logic [31:0]         ls_bus_read_data,
    output logic                bus_ack,
    output logic                ls_bus_stall,
    output logic                bus_err,
    input  logic                bus_err_clr,
    ls_bus_master_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [16:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic             w_req_any;
    logic             w_timeout;

    assign w_req_any = ls_bus_rd_en | ls_bus_wr_en;
    assign w_timeout = (r_cnt == LP_LAST) && !bus.bus_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any) w_next = S_REQ;
            S_REQ: begin
                // a ready in the last allowed cycle still completes normally
                if (bus.bus_ready)  w_next = S_DONE;
                else if (w_timeout) w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            // clear first so a same-cycle timeout set takes precedence
            if (bus_err_clr) r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_we    <= ls_bus_wr_en & ~ls_bus_rd_en;
                        r_addr  <= ls_bus_addr;
                        r_wdata <= ls_bus_write_data;
                        r_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    if (bus.bus_ready) begin
                        if (!r_we) r_rdata <= bus.bus_rdata;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (!r_we) r_rdata <= ERR_RDATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req       = (r_state == S_REQ);
    assign bus.bus_we        = r_we;
    assign bus.bus_addr      = r_addr;
    assign bus.bus_wdata     = r_wdata;
    assign bus_ack           = (r_state == S_DONE) || (r_state == S_ERR);
    assign ls_bus_read_data  = r_rdata;
    assign bus_err           = r_err;
    assign ls_bus_stall      = w_req_any & ~bus_ack;

endmodule

// File: tb/tb_ls_bus_master.sv
// tb/tb_ls_bus_master.sv - randomized and directed bench with transaction-level reference model
module tb_ls_bus_master;
    localparam int          T    = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset, rd_en, wr_en, err_clr;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic        ack, stall, err;

    always #5 clk = ~clk;

    ls_bus_master_if bif();

    ls_bus_master #(.TIMEOUT_CYCLES(T), .CNT_W(8), .ERR_RDATA(ERRD)) dut (
        .clk               (clk),
        .reset             (reset),
        .ls_bus_rd_en      (rd_en),
        .ls_bus_wr_en      (wr_en),
        .ls_bus_addr       (addr),
        .ls_bus_write_data (wdata),
        .ls_bus_read_data  (read_data),
        .bus_ack           (ack),
        .ls_bus_stall      (stall),
        .bus_err           (err),
        .bus_err_clr       (err_clr),
        .bus               (bif)
    );

    int checks = 0;
    int errors = 0;

    // transaction-level model state
    bit          m_valid = 0;
    bit          t_active, t_finish, t_we;
    int          t_age;
    logic [16:0] m_addr;
    logic [31:0] m_wdata, m_rdata;
    bit          m_err;

    // DUT outputs seen in the most recent cycle
    logic        ob_req, ob_ack, ob_we, ob_stall, ob_err;
    logic [16:0] ob_addr;
    logic [31:0] ob_wdata, ob_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // entered at posedge+1; samples mid-cycle, then advances the model across the edge
    task automatic step();
        bit exp_ack, exp_req, nerr;
        #3;
        ob_req = bif.bus_req; ob_ack = ack; ob_we = bif.bus_we; ob_stall = stall;
        ob_err = err; ob_addr = bif.bus_addr; ob_wdata = bif.bus_wdata; ob_rdata = read_data;
        if (m_valid) begin
            exp_ack = t_active && t_finish;
            exp_req = t_active && !t_finish;
            chk("m_bus_req",   {31'd0, ob_req},   {31'd0, exp_req});
            chk("m_bus_ack",   {31'd0, ob_ack},   {31'd0, exp_ack});
            chk("m_stall",     {31'd0, ob_stall}, {31'd0, (rd_en | wr_en) & !exp_ack});
            chk("m_bus_err",   {31'd0, ob_err},   {31'd0, m_err});
            chk("m_bus_we",    {31'd0, ob_we},    {31'd0, t_we});
            chk("m_bus_addr",  {15'd0, ob_addr},  {15'd0, m_addr});
            chk("m_bus_wdata", ob_wdata,          m_wdata);
            chk("m_read_data", ob_rdata,          m_rdata);
        end
        @(posedge clk);
        if (reset) begin
            t_active = 0; t_finish = 0; t_we = 0; t_age = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 0;
            m_valid = 1;
        end else begin
            nerr = m_err && !err_clr;
            if (t_active && t_finish) begin
                t_active = 0; t_finish = 0;
            end else if (t_active) begin
                if (bif.bus_ready) begin
                    if (!t_we) m_rdata = bif.bus_rdata;
                    t_finish = 1;
                end else if (t_age == T - 1) begin
                    t_finish = 1; nerr = 1;
                    if (!t_we) m_rdata = ERRD;
                end else begin
                    t_age++;
                end
            end else if (rd_en | wr_en) begin
                t_active = 1; t_we = wr_en && !rd_en;
                m_addr = addr; m_wdata = wdata; t_age = 0;
            end
            m_err = nerr;
        end
        #1;
    endtask

    task automatic quiet();
        reset = 0; rd_en = 0; wr_en = 0; err_clr = 0;
        bif.bus_ready = 0;
    endtask

    initial begin
        int  req_cnt, ack_cnt;
        bit  holding, seen;
        reset = 1; rd_en = 0; wr_en = 0; err_clr = 0;
        addr = '0; wdata = '0; bif.bus_ready = 0; bif.bus_rdata = '0;
        step(); step();
        quiet();
        step();
        chk("rst_req",   {31'd0, ob_req}, 32'd0);
        chk("rst_ack",   {31'd0, ob_ack}, 32'd0);
        chk("rst_rdata", ob_rdata,        32'd0);

        // read, zero wait
        rd_en = 1; addr = 17'h1_4000;
        step();
        chk("rd0_stall_c0", {31'd0, ob_stall}, 32'd1);
        bif.bus_ready = 1; bif.bus_rdata = 32'hCAFE_0001;
        step();
        chk("rd0_req_c1",  {31'd0, ob_req},   32'd1);
        chk("rd0_we_c1",   {31'd0, ob_we},    32'd0);
        chk("rd0_addr_c1", {15'd0, ob_addr},  32'h0001_4000);
        chk("rd0_stall_c1",{31'd0, ob_stall}, 32'd1);
        bif.bus_ready = 0;
        step();
        chk("rd0_ack_c2",   {31'd0, ob_ack},   32'd1);
        chk("rd0_rdata_c2", ob_rdata,          32'hCAFE_0001);
        chk("rd0_stall_c2", {31'd0, ob_stall}, 32'd0);
        rd_en = 0;
        step();

        // write, 3 wait states
        wr_en = 1; addr = 17'h0_C010; wdata = 32'h1234_5678;
        step();
        for (int i = 0; i < 4; i++) begin
            bif.bus_ready = (i == 3);
            step();
            chk("wr_req",   {31'd0, ob_req}, 32'd1);
            chk("wr_we",    {31'd0, ob_we},  32'd1);
            chk("wr_wdata", ob_wdata,        32'h1234_5678);
        end
        bif.bus_ready = 0;
        step();
        chk("wr_ack",   {31'd0, ob_ack}, 32'd1);
        chk("wr_rdata", ob_rdata,        32'hCAFE_0001);
        wr_en = 0;
        step();
        chk("wr_ack_single", {31'd0, ob_ack}, 32'd0);

        // timeout read
        rd_en = 1; addr = 17'h0_0123;
        step();
        req_cnt = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (ob_req) req_cnt++;
            if (ob_ack) seen = 1;
        end
        chk("to_ack_seen", {31'd0, seen}, 32'd1);
        chk("to_req_cycles", req_cnt, T);
        chk("to_rdata", ob_rdata, ERRD);
        chk("to_err", {31'd0, ob_err}, 32'd1);
        rd_en = 0; bif.bus_ready = 1; bif.bus_rdata = 32'h5555_AAAA;
        step(); step();
        chk("to_late_ready_req", {31'd0, ob_req}, 32'd0);
        chk("to_late_ready_rd",  ob_rdata,        ERRD);
        chk("to_err_sticky",     {31'd0, ob_err}, 32'd1);
        bif.bus_ready = 0; err_clr = 1;
        step();
        err_clr = 0;
        step();
        chk("to_err_cleared", {31'd0, ob_err}, 32'd0);

        // both enables: read wins
        rd_en = 1; wr_en = 1; addr = 17'h1_FFFF; wdata = 32'h0BAD_F00D;
        step();
        bif.bus_ready = 1; bif.bus_rdata = 32'h7777_0000;
        step();
        chk("both_we", {31'd0, ob_we}, 32'd0);
        bif.bus_ready = 0;
        step();
        chk("both_rdata", ob_rdata, 32'h7777_0000);
        rd_en = 0; wr_en = 0;
        step();

        // reset in the 2nd REQ cycle
        wr_en = 1; addr = 17'h0_0F0F; wdata = 32'hA5A5_A5A5;
        step();
        step();
        reset = 1;
        step();
        chk("rst2_req_in", {31'd0, ob_req}, 32'd1);
        reset = 0; wr_en = 0;
        step();
        chk("rst2_req",   {31'd0, ob_req},  32'd0);
        chk("rst2_ack",   {31'd0, ob_ack},  32'd0);
        chk("rst2_addr",  {15'd0, ob_addr}, 32'd0);
        chk("rst2_wdata", ob_wdata,         32'd0);
        chk("rst2_rdata", ob_rdata,         32'd0);
        rd_en = 1; addr = 17'h0_0042;
        step();
        bif.bus_ready = 1; bif.bus_rdata = 32'h0000_0042;
        step();
        bif.bus_ready = 0;
        step();
        chk("rst2_new_ack",   {31'd0, ob_ack}, 32'd1);
        chk("rst2_new_rdata", ob_rdata,        32'h0000_0042);
        rd_en = 0;
        step();

        // back-to-back read then write
        ack_cnt = 0; req_cnt = 0;
        rd_en = 1; addr = 17'h0_1000;
        step();
        bif.bus_ready = 1; bif.bus_rdata = 32'h1111_2222;
        step(); req_cnt += ob_req;
        bif.bus_ready = 0;
        step(); ack_cnt += ob_ack; req_cnt += ob_req;
        rd_en = 0; wr_en = 1; addr = 17'h0_2000; wdata = 32'h3333_4444;
        step(); ack_cnt += ob_ack; req_cnt += ob_req;
        chk("b2b_idle_gap", {30'd0, ob_req, ob_ack}, 32'd0);
        bif.bus_ready = 1;
        step(); req_cnt += ob_req;
        chk("b2b_wr_we", {31'd0, ob_we}, 32'd1);
        bif.bus_ready = 0;
        step(); ack_cnt += ob_ack; req_cnt += ob_req;
        wr_en = 0;
        step(); ack_cnt += ob_ack; req_cnt += ob_req;
        chk("b2b_acks", ack_cnt, 2);
        chk("b2b_reqs", req_cnt, 2);

        // randomized traffic against the model
        holding = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!holding && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin rd_en = 1; wr_en = 0; end
                    1: begin rd_en = 0; wr_en = 1; end
                    default: begin rd_en = 1; wr_en = 1; end
                endcase
                holding = 1;
            end
            addr = 17'($urandom);
            wdata = $urandom;
            bif.bus_ready = ($urandom_range(0, 3) == 0);
            bif.bus_rdata = $urandom;
            err_clr = ($urandom_range(0, 9) == 0);
            step();
            if (ob_ack || reset) begin
                holding = 0; rd_en = 0; wr_en = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ls_bus_master.md
Name: ls_bus_master

Overview:
- Sits directly downstream of the load/store controller's external-bus port.
- Converts the controller's level-held bus read/write enables into a registered request/ready handshake on the external peripheral bus.
- Returns read data and a single-cycle completion pulse (bus_ack) to the controller, and produces a core stall while a bus transaction is outstanding.
- Bounds every transaction with a timeout, which completes the access with an error flag.

Parameters:
TIMEOUT_CYCLES, 255, number of REQ-state cycles without bus_ready before the transaction is abandoned (1..2^CNT_W-1)
CNT_W, 8, width of the timeout counter
ERR_RDATA, 32'h0000_0000, read data returned to the core on a timed-out read

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
ls_bus_rd_en  input  1  read request from load/store controller, held until bus_ack
ls_bus_wr_en  input  1  write request from load/store controller, held until bus_ack
ls_bus_addr  input  17  word address from controller
ls_bus_write_data  input  32  write data from controller
ls_bus_read_data  output  32  read data to controller, valid in the bus_ack cycle
bus_ack  output  1  one-cycle completion pulse to controller
ls_bus_stall  output  1  stall to core while a request is pending and not acked
bus_err  output  1  sticky timeout flag
bus_err_clr  input  1  clears bus_err
bus_req  output  1  external bus request
bus_we  output  1  external bus write (1) / read (0)
bus_addr  output  17  external bus address
bus_wdata  output  32  external bus write data
bus_rdata  input  32  external bus read data, valid when bus_ready=1
bus_ready  input  1  external bus completion handshake

Behaviour:
- Reset values: state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, ls_bus_read_data=0, bus_ack=0, bus_err=0, counter=0.
- Reset is synchronous. Asserting it mid-transaction forces IDLE with bus_req=0 at the next edge. No ack is produced.
- IDLE:
  - If ls_bus_rd_en or ls_bus_wr_en is 1 at an edge, register addr, wdata and we (we = wr_en & !rd_en; read has priority if both are set).
  - Then go to REQ and clear the counter.
- REQ:
  - bus_req=1; bus_addr, bus_wdata and bus_we are held stable from the registers.
  - On an edge with bus_ready=1: capture bus_rdata into ls_bus_read_data (reads only; writes leave it unchanged), then go to DONE.
  - Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1 and bus_ready=0, go to ERR.
  - bus_ready takes precedence over timeout in the same cycle.
- DONE: bus_req=0, bus_ack=1 for exactly one cycle, then IDLE.
- ERR:
  - bus_req=0, bus_ack=1 for one cycle, bus_err set to 1.
  - For reads, ls_bus_read_data=ERR_RDATA. Then IDLE.
- bus_ready seen while not in REQ is ignored.
- Minimum latency: request visible at edge N → bus_req high in cycle N+1 → with bus_ready=1 in that cycle, bus_ack high in cycle N+2.
- Back-to-back: the controller advances on the edge ending the ack cycle. IDLE then accepts a new request at the next edge, giving one idle cycle between transactions. Enables are not resampled in DONE/ERR.
- ls_bus_stall = (ls_bus_rd_en | ls_bus_wr_en) & !bus_ack. This is combinational so the core freezes in the request cycle itself.
- bus_err:
  - Set in ERR.
  - Cleared by bus_err_clr at the next edge.
  - Set wins if both occur in the same cycle.
- Request changes while in REQ are ignored; the registered transaction completes unchanged.

Test Plan:
- Read, zero wait: rd_en=1, addr=17'h1_4000 at cycle 0; bus_ready=1 with rdata=32'hCAFE_0001 in cycle 1 → bus_req/bus_we=0/bus_addr=17'h1_4000 in cycle 1; bus_ack=1 and ls_bus_read_data=32'hCAFE_0001 in cycle 2; stall high in cycles 0–1 only.
- Write, 3 wait states: wr_en=1, addr=17'h0_C010, data=32'h1234_5678; bus_ready asserted in the 4th REQ cycle → bus_we=1 and bus_wdata stable for all 4 cycles, single bus_ack pulse, read data unchanged.
- Timeout: TIMEOUT_CYCLES=4, read with bus_ready held 0 → bus_req high exactly 4 cycles, then bus_ack pulse, ls_bus_read_data=ERR_RDATA, bus_err=1 until bus_err_clr pulse; a late bus_ready is ignored.
- Simultaneous rd_en=wr_en=1 → bus_we=0 (read performed).
- Reset mid-REQ: reset asserted in 2nd REQ cycle → next cycle bus_req=0, bus_ack=0, all outputs at reset values; new request then completes normally.
- Back-to-back read then write → exactly one idle cycle between transactions, two bus_ack pulses, no duplicate bus_req.
